// File: rtl/ems_pkg.sv
// rtl/ems_pkg.sv - shared types and geometry for the EMS SDRAM bridge
package ems_pkg;

  // Default byte-address reach; also used by the EMS mapper
  localparam int EMS_ADR_WIDTH  = 24;
  // Default line geometry: 4 halfwords, matching the controller burst length
  localparam int EMS_LINE_LOG2  = 2;
  localparam int EMS_LINE_WORDS = 1 << EMS_LINE_LOG2;
  // One CPU halfword per 4-byte slot, so the word index starts at bit 2
  localparam int IDX_LSB        = 2;
  localparam int EMS_TAG_LSB    = IDX_LSB + EMS_LINE_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_FILL,
    WR_REQ,
    ACK
  } state_t;

endpackage

// File: rtl/ems_line_buf.sv
// rtl/ems_line_buf.sv - single-line read buffer with tag/valid and hit compare
module ems_line_buf
  import ems_pkg::*;
#(
  parameter int LINE_LOG2 = EMS_LINE_LOG2,
  parameter int TAG_W     = EMS_ADR_WIDTH - IDX_LSB - EMS_LINE_LOG2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [TAG_W-1:0]     i_tag,
  input  logic                 i_tag_ld,
  input  logic                 i_set_valid,
  output logic                 o_hit,
  input  logic                 i_wr_en,
  input  logic [LINE_LOG2-1:0] i_wr_idx,
  input  logic [1:0]           i_wr_be,
  input  logic [15:0]          i_wr_dat,
  input  logic                 i_fill_en,
  input  logic [LINE_LOG2-1:0] i_fill_idx,
  input  logic [15:0]          i_fill_dat,
  input  logic [LINE_LOG2-1:0] i_rd_idx,
  output logic [15:0]          o_rd_dat
);
  localparam int LINE_WORDS = 1 << LINE_LOG2;

  logic [TAG_W-1:0] r_tag;
  logic             r_valid;
  logic [15:0]      r_line [LINE_WORDS];

  // Tag/valid: a new miss invalidates and retags; the last fill word validates
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else if (i_tag_ld) begin
      r_tag   <= i_tag;
      r_valid <= 1'b0;
    end else if (i_set_valid) begin
      r_valid <= 1'b1;
    end
  end

  // Data array: burst fill words, or byte-masked write-hit updates
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LINE_WORDS; i++) r_line[i] <= '0;
    end else if (i_fill_en) begin
      r_line[i_fill_idx] <= i_fill_dat;
    end else if (i_wr_en) begin
      if (i_wr_be[0]) r_line[i_wr_idx][7:0]  <= i_wr_dat[7:0];
      if (i_wr_be[1]) r_line[i_wr_idx][15:8] <= i_wr_dat[15:8];
    end
  end

  assign o_hit    = r_valid && (r_tag == i_tag);
  assign o_rd_dat = r_line[i_rd_idx];

endmodule

// File: rtl/ems_sdram_bridge.sv
// rtl/ems_sdram_bridge.sv - Wishbone to SDRAM controller bridge with one-line read buffer
module ems_sdram_bridge
  import ems_pkg::*;
#(
  parameter int ADR_WIDTH = EMS_ADR_WIDTH,
  parameter int LINE_LOG2 = EMS_LINE_LOG2
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic [15:0]          wb_dat_i,
  output logic [15:0]          wb_dat_o,
  input  logic [1:0]           wb_sel_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  input  logic [31:0]          sdram_adr_i,
  output logic                 ctl_req,
  output logic                 ctl_we,
  output logic [ADR_WIDTH-3:0] ctl_adr,
  output logic [1:0]           ctl_be,
  output logic [15:0]          ctl_wdat,
  input  logic                 ctl_gnt,
  input  logic [15:0]          ctl_rdat,
  input  logic                 ctl_rvalid
);
  localparam int TAG_LSB = IDX_LSB + LINE_LOG2;
  localparam int TAG_W   = ADR_WIDTH - TAG_LSB;
  localparam logic [LINE_LOG2-1:0] LAST_WORD = LINE_LOG2'((1 << LINE_LOG2) - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LINE_LOG2-1:0] r_idx;
  logic [LINE_LOG2-1:0] r_cnt;
  logic                 r_abort;

  logic [ADR_WIDTH-3:0] w_slot;
  logic [TAG_W-1:0]     w_tag;
  logic [LINE_LOG2-1:0] w_idx;
  logic [LINE_LOG2-1:0] w_rd_idx;
  logic [15:0]          w_rd_dat;
  logic                 w_hit, w_req, w_keep;
  logic                 w_start_rd, w_start_wr, w_rd_hit, w_fill, w_fill_last, w_busy;
  logic                 w_unused_adr;

  assign w_slot       = sdram_adr_i[ADR_WIDTH-1:IDX_LSB];
  assign w_tag        = sdram_adr_i[ADR_WIDTH-1:TAG_LSB];
  assign w_idx        = sdram_adr_i[TAG_LSB-1:IDX_LSB];
  assign w_unused_adr = &{1'b0, sdram_adr_i[31:ADR_WIDTH], sdram_adr_i[IDX_LSB-1:0]};
  assign w_req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  // Completion acks only if the master has held the cycle throughout
  assign w_keep       = wb_cyc_i & ~r_abort;
  assign w_rd_idx     = (r_state == IDLE) ? w_idx : r_idx;

  ems_line_buf #(
    .LINE_LOG2 (LINE_LOG2),
    .TAG_W     (TAG_W)
  ) u_line_buf (
    .i_clk       (wb_clk),
    .i_rst       (wb_rst),
    .i_tag       (w_tag),
    .i_tag_ld    (w_start_rd),
    .i_set_valid (w_fill_last),
    .o_hit       (w_hit),
    .i_wr_en     (w_start_wr & w_hit),
    .i_wr_idx    (w_idx),
    .i_wr_be     (wb_sel_i),
    .i_wr_dat    (wb_dat_i),
    .i_fill_en   (w_fill),
    .i_fill_idx  (r_cnt),
    .i_fill_dat  (ctl_rdat),
    .i_rd_idx    (w_rd_idx),
    .o_rd_dat    (w_rd_dat)
  );

  // State register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rd_hit) w_state_nxt = ACK;
               else if (w_start_rd) w_state_nxt = RD_REQ;
               else if (w_start_wr) w_state_nxt = WR_REQ;
      RD_REQ:  if (ctl_gnt) w_state_nxt = RD_FILL;
      RD_FILL: if (w_fill_last) w_state_nxt = w_keep ? ACK : IDLE;
      WR_REQ:  if (ctl_gnt) w_state_nxt = w_keep ? ACK : IDLE;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state control decode driving the datapath and line buffer
  always_comb begin
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;
    w_rd_hit    = 1'b0;
    w_fill      = 1'b0;
    w_fill_last = 1'b0;
    w_busy      = (r_state == RD_REQ) || (r_state == RD_FILL) || (r_state == WR_REQ);
    if (r_state == IDLE && w_req) begin
      if (wb_we_i)    w_start_wr = 1'b1;
      else if (w_hit) w_rd_hit   = 1'b1;
      else            w_start_rd = 1'b1;
    end
    if (r_state == RD_FILL && ctl_rvalid) begin
      w_fill      = 1'b1;
      w_fill_last = (r_cnt == LAST_WORD);
    end
  end

  // Registered bus and controller outputs, fill counter and abort tracking
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctl_req  <= 1'b0;
      ctl_we   <= 1'b0;
      ctl_adr  <= '0;
      ctl_be   <= '0;
      ctl_wdat <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_abort  <= 1'b0;
    end else begin
      wb_ack_o <= (w_state_nxt == ACK);
      if (w_rd_hit) wb_dat_o <= w_rd_dat;
      if (w_start_rd) begin
        ctl_req <= 1'b1;
        ctl_we  <= 1'b0;
        ctl_adr <= {w_tag, {LINE_LOG2{1'b0}}};
        r_idx   <= w_idx;
        r_abort <= 1'b0;
      end
      if (w_start_wr) begin
        ctl_req  <= 1'b1;
        ctl_we   <= 1'b1;
        ctl_adr  <= w_slot;
        ctl_be   <= wb_sel_i;
        ctl_wdat <= wb_dat_i;
        r_abort  <= 1'b0;
      end
      if ((r_state == RD_REQ || r_state == WR_REQ) && ctl_gnt) ctl_req <= 1'b0;
      if (w_busy && !wb_cyc_i) r_abort <= 1'b1;
      if (w_fill) begin
        r_cnt <= r_cnt + 1'b1;
        // The requested word may be the one arriving right now
        if (w_fill_last) wb_dat_o <= (r_idx == r_cnt) ? ctl_rdat : w_rd_dat;
      end
    end
  end

endmodule

// File: tb/tb_ems_sdram_bridge.sv
// tb/tb_ems_sdram_bridge.sv - self-checking bench for ems_sdram_bridge
module tb_ems_sdram_bridge;

  logic        wb_clk, wb_rst;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [31:0] sdram_adr_i;
  logic        ctl_req, ctl_we, ctl_gnt, ctl_rvalid;
  logic [21:0] ctl_adr;
  logic [1:0]  ctl_be;
  logic [15:0] ctl_wdat, ctl_rdat;

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_q [$];
  logic [40:0] req_q [$];

  ems_sdram_bridge dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_i    (wb_sel_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_ack_o    (wb_ack_o),
    .sdram_adr_i (sdram_adr_i),
    .ctl_req     (ctl_req),
    .ctl_we      (ctl_we),
    .ctl_adr     (ctl_adr),
    .ctl_be      (ctl_be),
    .ctl_wdat    (ctl_wdat),
    .ctl_gnt     (ctl_gnt),
    .ctl_rdat    (ctl_rdat),
    .ctl_rvalid  (ctl_rvalid)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [15:0] d, input logic [1:0] sel);
    sdram_adr_i = a;
    wb_we_i     = we;
    wb_dat_i    = d;
    wb_sel_i    = sel;
    wb_cyc_i    = 1'b1;
    wb_stb_i    = 1'b1;
  endtask

  task automatic serve_req(input string name);
    int n;
    logic [40:0] got, exp;
    n = 0;
    while (!ctl_req && n < 16) begin tick(); n++; end
    checks++;
    if (ctl_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: got ctl_req=%b expected 1 within 16 cycles", name, ctl_req);
      return;
    end
    exp = req_q.pop_front();
    got = {ctl_we, ctl_adr, ctl_we ? ctl_be : 2'b00, ctl_we ? ctl_wdat : 16'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_fields: got %h expected %h", name, got, exp);
    end
    tick();
    checks++;
    if (ctl_req !== 1'b1 || ctl_adr !== exp[39:18]) begin
      errors++;
      $display("FAIL %s_hold: got req=%b adr=%h expected req=1 adr=%h", name, ctl_req, ctl_adr, exp[39:18]);
    end
    ctl_gnt = 1'b1;
    tick();
    ctl_gnt = 1'b0;
    checks++;
    if (ctl_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: got ctl_req=%b expected 0", name, ctl_req);
    end
  endtask

  task automatic send_word(input logic [15:0] d);
    ctl_rvalid = 1'b1;
    ctl_rdat   = d;
    tick();
    ctl_rvalid = 1'b0;
    ctl_rdat   = 16'hxxxx;
  endtask

  task automatic burst(input logic [63:0] w);
    send_word(w[15:0]);
    send_word(w[31:16]);
    tick();
    send_word(w[47:32]);
    send_word(w[63:48]);
  endtask

  task automatic wait_ack(input string name, input int lat, input bit no_req, input bit chain, input logic [31:0] nxt);
    int n;
    bit saw_req;
    logic [15:0] e;
    n = 0;
    saw_req = 0;
    while (!wb_ack_o && n < 32) begin
      if (ctl_req) saw_req = 1;
      tick();
      n++;
    end
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack: got wb_ack_o=%b expected 1 within 32 cycles", name, wb_ack_o);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      return;
    end
    if (lat >= 0) begin
      checks++;
      if (n != lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, lat);
      end
    end
    if (no_req) begin
      checks++;
      if (saw_req || ctl_req) begin
        errors++;
        $display("FAIL %s_no_req: got ctl_req activity expected none", name);
      end
    end
    if (!wb_we_i) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL %s_unexpected: got read ack with data %h expected no read", name, wb_dat_o);
      end else begin
        e = rd_q.pop_front();
        if (wb_dat_o !== e) begin
          errors++;
          $display("FAIL %s_data: got %h expected %h", name, wb_dat_o, e);
        end
      end
    end
    if (chain) sdram_adr_i = nxt;
    else begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
    end
    tick();
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack_width: got wb_ack_o=%b expected 0", name, wb_ack_o);
    end
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
    checks++;
    if ({wb_ack_o, ctl_req, ctl_we, ctl_adr, ctl_be, ctl_wdat, wb_dat_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {wb_ack_o, ctl_req, ctl_we, ctl_adr, ctl_be, ctl_wdat, wb_dat_o});
    end
    #2 wb_rst = 1'b0;
    tick();
  endtask

  task automatic test_read_miss();
    issue(32'h0000_0014, 1'b0, 16'h0, 2'b00);
    req_q.push_back({1'b0, 22'h4, 2'b00, 16'h0});
    rd_q.push_back(16'h2222);
    serve_req("miss1");
    burst(64'h4444_3333_2222_1111);
    wait_ack("miss1", 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_read_hit();
    issue(32'h0000_001C, 1'b0, 16'h0, 2'b00);
    rd_q.push_back(16'h4444);
    wait_ack("hit1", 1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_write_hit();
    issue(32'h0000_0018, 1'b1, 16'hABCD, 2'b01);
    req_q.push_back({1'b1, 22'h6, 2'b01, 16'hABCD});
    serve_req("wr1");
    wait_ack("wr1", 0, 1'b0, 1'b0, 32'h0);
    issue(32'h0000_0018, 1'b0, 16'h0, 2'b00);
    rd_q.push_back(16'h33CD);
    wait_ack("wr_readback", 1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_new_tag();
    issue(32'h0000_0100, 1'b0, 16'h0, 2'b00);
    req_q.push_back({1'b0, 22'h40, 2'b00, 16'h0});
    rd_q.push_back(16'h5555);
    serve_req("newtag");
    burst(64'h8888_7777_6666_5555);
    wait_ack("newtag", 0, 1'b0, 1'b0, 32'h0);
    issue(32'h0000_0014, 1'b0, 16'h0, 2'b00);
    req_q.push_back({1'b0, 22'h4, 2'b00, 16'h0});
    rd_q.push_back(16'h9002);
    serve_req("remiss");
    burst(64'h9004_9003_9002_9001);
    wait_ack("remiss", 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_cyc_drop();
    bit acked;
    issue(32'h0000_0204, 1'b0, 16'h0, 2'b00);
    req_q.push_back({1'b0, 22'h80, 2'b00, 16'h0});
    serve_req("drop");
    send_word(16'hB000);
    send_word(16'hB001);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    acked = 0;
    send_word(16'hB002);
    if (wb_ack_o) acked = 1;
    send_word(16'hB003);
    for (int i = 0; i < 3; i++) begin
      if (wb_ack_o) acked = 1;
      tick();
    end
    checks++;
    if (acked) begin
      errors++;
      $display("FAIL drop_no_ack: got wb_ack_o=1 expected 0");
    end
    issue(32'h0000_0208, 1'b0, 16'h0, 2'b00);
    rd_q.push_back(16'hB002);
    wait_ack("drop_hit", 1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_burst();
    issue(32'h0000_0300, 1'b0, 16'h0, 2'b00);
    req_q.push_back({1'b0, 22'hC0, 2'b00, 16'h0});
    serve_req("rstb");
    send_word(16'hDEAD);
    #3 wb_rst = 1'b1;
    #1;
    checks++;
    if ({wb_ack_o, ctl_req, ctl_we, ctl_adr, ctl_be, ctl_wdat, wb_dat_o} !== '0) begin
      errors++;
      $display("FAIL rstb_async: got %h expected 0",
               {wb_ack_o, ctl_req, ctl_we, ctl_adr, ctl_be, ctl_wdat, wb_dat_o});
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    #2 wb_rst = 1'b0;
    tick();
    send_word(16'hBEEF);
    send_word(16'hBEEF);
    checks++;
    if (wb_ack_o !== 1'b0 || ctl_req !== 1'b0) begin
      errors++;
      $display("FAIL rstb_stray: got ack=%b req=%b expected 0 0", wb_ack_o, ctl_req);
    end
    issue(32'h0000_030C, 1'b0, 16'h0, 2'b00);
    req_q.push_back({1'b0, 22'hC0, 2'b00, 16'h0});
    rd_q.push_back(16'hC003);
    serve_req("rstb_remiss");
    burst(64'hC003_C002_C001_C000);
    wait_ack("rstb_fwd", 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0300, 1'b0, 16'h0, 2'b00);
    rd_q.push_back(16'hC000);
    rd_q.push_back(16'hC001);
    rd_q.push_back(16'hC002);
    wait_ack("b2b0", 1, 1'b1, 1'b1, 32'h0000_0304);
    wait_ack("b2b1", 1, 1'b1, 1'b1, 32'hFF00_0308);
    wait_ack("b2b2_hiadr", 1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (rd_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d reads %0d reqs left expected 0 0", rd_q.size(), req_q.size());
    end
  endtask

  initial begin
    wb_rst      = 1'b1;
    wb_dat_i    = '0;
    wb_sel_i    = '0;
    wb_cyc_i    = 1'b0;
    wb_stb_i    = 1'b0;
    wb_we_i     = 1'b0;
    sdram_adr_i = '0;
    ctl_gnt     = 1'b0;
    ctl_rdat    = '0;
    ctl_rvalid  = 1'b0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_new_tag();
    test_cyc_drop();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ems_sdram_bridge.md
Name: ems_sdram_bridge

Overview:
- Wishbone slave for the CPU memory arena. Sits directly downstream of the EMS mapper and consumes its translated address (sdram_adr_o → sdram_adr_i here).
- Converts 16-bit Wishbone cycles into requests on the SDRAM controller's request/grant/burst-read port.
- Holds a single-line read buffer (LINE_WORDS halfwords) so sequential CPU fetches hit without a controller round-trip.
- Writes go straight through to the controller; the buffer is updated on a write hit.

Parameters:
ADR_WIDTH, 24, byte-address bits forwarded to the controller (bits [ADR_WIDTH-1:2] used; 16MB reach, covers 8MB EMS space)
LINE_LOG2, 2, log2 of halfwords per buffer line; LINE_WORDS = 4 = controller read burst length

Ports:
wb_clk  in  1  clock, all logic on rising edge
wb_rst  in  1  asynchronous, active-high reset
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data, valid while wb_ack_o=1
wb_sel_i  in  2  byte lane enables
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_ack_o  out  1  single-cycle acknowledge
sdram_adr_i  in  32  translated address from EMS mapper; bits[1:0] always 0; one CPU halfword per 4-byte slot
ctl_req  out  1  controller request, held until ctl_gnt
ctl_we  out  1  1=write, 0=burst read
ctl_adr  out  ADR_WIDTH-2  slot address = sdram_adr_i[ADR_WIDTH-1:2]; line-aligned on reads
ctl_be  out  2  write byte enables (= wb_sel_i)
ctl_wdat  out  16  write data
ctl_gnt  in  1  controller accepted request (1-cycle pulse)
ctl_rdat  in  16  read burst data
ctl_rvalid  in  1  one pulse per burst word, in ascending address order

Behaviour:
Reset and idle:
- On wb_rst, asynchronously: state=IDLE; wb_ack_o, ctl_req, ctl_we = 0; ctl_adr, ctl_be, ctl_wdat, wb_dat_o = 0; buffer valid=0; fill counter=0.
- Tag = sdram_adr_i[ADR_WIDTH-1:LINE_LOG2+2]. Index = sdram_adr_i[LINE_LOG2+1:2].
- Request = wb_cyc_i & wb_stb_i & ~wb_ack_o, sampled in IDLE only.

State machine:
- IDLE, read, hit (valid and tag equal): go to ACK. Next cycle wb_ack_o=1 with wb_dat_o=line[index] (1-cycle latency). No controller activity.
- IDLE, read, miss: go to RD_REQ. ctl_req=1, ctl_we=0, ctl_adr=line-aligned slot (index bits zero). Clear valid; latch tag and index.
- RD_REQ: hold outputs stable until ctl_gnt, then drop ctl_req and go to RD_FILL.
- RD_FILL: each ctl_rvalid writes ctl_rdat to line[count] and increments count. On the LINE_WORDS-th word: set valid, count wraps to 0, go to ACK with wb_dat_o=line[latched index]. When the last word is the requested one, its data is forwarded from ctl_rdat in the same cycle.
- IDLE, write: go to WR_REQ. ctl_req=1, ctl_we=1, ctl_adr=slot, ctl_be=wb_sel_i, ctl_wdat=wb_dat_i.
  - Write hit: update only the enabled bytes of line[index] in the same cycle.
  - wb_sel_i=0: no buffer change, controller write still issued.
- WR_REQ: on ctl_gnt drop ctl_req and go to ACK. Writes do not wait for SDRAM completion.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE. Back-to-back requests: IDLE samples the next request the cycle after ACK, so consecutive hits take 2 cycles each.

Boundary and error cases:
- wb_cyc_i dropped during RD_REQ or RD_FILL: the burst still completes and the buffer becomes valid, but ACK is suppressed and state returns to IDLE. Same rule for WR_REQ: the write completes and no ack is issued.
- ctl_rvalid outside RD_FILL: ignored.
- Reset mid-burst: the controller must tolerate ctl_req deasserting before ctl_gnt and must discard remaining rvalid pulses. The bridge ignores them, since state=IDLE.
- Address bits above ADR_WIDTH-1: ignored.
- count is LINE_LOG2 bits and wraps naturally.

Decomposition:
- Shared package ems_pkg holds:
  - state enum (IDLE, RD_REQ, RD_FILL, WR_REQ, ACK);
  - localparams LINE_WORDS and the tag/index bit positions;
  - ADR_WIDTH default, shared with the EMS mapper.
- One natural sub-module, ems_line_buf: LINE_WORDS×16 register file with tag/valid, byte-masked write port, fill write port and hit compare.

Test Plan:
1. Read miss at sdram_adr_i=0x0000_0014: ctl_adr=0x4 (line-aligned), ctl_we=0. Burst 0x1111,0x2222,0x3333,0x4444 → wb_ack_o one cycle after 4th rvalid with wb_dat_o=0x2222.
2. Read hit at 0x0000_001C after test 1: ack next cycle, wb_dat_o=0x4444, ctl_req stays 0.
3. Write 0xABCD, sel=2'b01, to 0x0000_0018 (hit): ctl_be=01, ctl_wdat=0xABCD. Ack after gnt; a subsequent read of 0x18 hits and returns 0x33CD.
4. Read miss to a new tag 0x0000_0100: buffer invalidated and refilled, ctl_adr=0x40. A reread of 0x14 misses again.
5. Drop wb_cyc_i mid-fill after the 2nd rvalid: no wb_ack_o. After the fill the state is IDLE and buffer valid; a next read of the same line hits.
6. Assert wb_rst between gnt and the 2nd rvalid: all outputs 0 immediately (asynchronous). Stray rvalid pulses ignored; the next read misses.
